// File: rtl/switch_debounce_if.sv
// Switch bundle between raw board switches and the debouncer: raw levels in,
// clean levels plus rise/fall event pulses out.
interface switch_debounce_if #(
  parameter int c_NUM_SW = 2
);
  logic [c_NUM_SW-1:0] i_switch;
  logic [c_NUM_SW-1:0] o_switch;
  logic [c_NUM_SW-1:0] o_rise;
  logic [c_NUM_SW-1:0] o_fall;

  modport master (output i_switch, input o_switch, o_rise, o_fall);
  modport slave  (input i_switch, output o_switch, o_rise, o_fall);
endinterface

// File: rtl/switch_debounce.sv
// Per-channel switch debouncer with registered rise/fall pulses; define
// SWITCH_DEBOUNCE_SYNC_EN to insert a 2-flop synchroniser ahead of the counters.
module switch_debounce #(
  parameter int c_NUM_SW       = 2,
  parameter int c_DEBOUNCE_CNT = 250,
  parameter int c_CNT_W        = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  switch_debounce_if.slave sw
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_DEBOUNCE_CNT - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  logic [c_NUM_SW-1:0] s;

`ifdef SWITCH_DEBOUNCE_SYNC_EN
  logic [c_NUM_SW-1:0] sync1_q;
  logic [c_NUM_SW-1:0] sync2_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw.i_switch;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  // Inputs are already synchronous to i_clock; compare them directly.
  assign s = sw.i_switch;
`endif

  state_t              state_q [c_NUM_SW];
  state_t              state_d [c_NUM_SW];
  logic [c_CNT_W-1:0]  cnt_q   [c_NUM_SW];
  logic [c_CNT_W-1:0]  cnt_d   [c_NUM_SW];
  logic [c_NUM_SW-1:0] level_q;
  logic [c_NUM_SW-1:0] level_d;
  logic [c_NUM_SW-1:0] rise_q;
  logic [c_NUM_SW-1:0] rise_d;
  logic [c_NUM_SW-1:0] fall_q;
  logic [c_NUM_SW-1:0] fall_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int n = 0; n < c_NUM_SW; n++) begin
        state_q[n] <= ST_STABLE;
        cnt_q[n]   <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int n = 0; n < c_NUM_SW; n++) begin
        state_q[n] <= state_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int n = 0; n < c_NUM_SW; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      case (state_q[n])
        ST_STABLE: begin
          if (s[n] != level_q[n]) begin
            cnt_d[n]   = c_ONE;
            state_d[n] = ST_PENDING;
          end else begin
            cnt_d[n] = '0;
          end
        end
        ST_PENDING: begin
          if (s[n] == level_q[n]) begin
            // Bounce back to the accepted level: drop the partial count.
            cnt_d[n]   = '0;
            state_d[n] = ST_STABLE;
          end else if (cnt_q[n] == c_LAST) begin
            level_d[n] = s[n];
            rise_d[n]  = s[n];
            fall_d[n]  = ~s[n];
            cnt_d[n]   = '0;
            state_d[n] = ST_STABLE;
          end else begin
            cnt_d[n] = cnt_q[n] + c_ONE;
          end
        end
        default: begin
          cnt_d[n]   = '0;
          state_d[n] = ST_STABLE;
        end
      endcase
    end
  end

  assign sw.o_switch = level_q;
  assign sw.o_rise   = rise_q;
  assign sw.o_fall   = fall_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a sliding-window reference model.
module tb_switch_debounce;

  localparam int NSW = 2;
  localparam int DEB = 4;
`ifdef SWITCH_DEBOUNCE_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int LAT  = DEB + 2;
`else
  localparam bit SYNC = 1'b0;
  localparam int LAT  = DEB;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  switch_debounce_if #(.c_NUM_SW(NSW)) sw_if ();

  switch_debounce #(
    .c_NUM_SW      (NSW),
    .c_DEBOUNCE_CNT(DEB),
    .c_CNT_W       (16)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .sw     (sw_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a channel adopts a new level once its last DEB compared samples
  // all disagree with the current level; samples before a reset or before
  // the last level change never count.
  logic [NSW-1:0] m_o, m_rise, m_fall, m_sync1, m_s;
  bit             win   [NSW][DEB];
  int             valid [NSW];

  initial begin
    m_o = '0; m_rise = '0; m_fall = '0; m_sync1 = '0; m_s = '0;
    for (int n = 0; n < NSW; n++) valid[n] = 0;
  end

  always @(posedge clk) begin
    logic [NSW-1:0] cur;
    bit all_diff;
    if (rst) begin
      m_o = '0; m_rise = '0; m_fall = '0; m_sync1 = '0; m_s = '0;
      for (int n = 0; n < NSW; n++) valid[n] = 0;
    end else begin
      cur = SYNC ? m_s : sw_if.i_switch;
      if (SYNC) begin
        m_s     = m_sync1;
        m_sync1 = sw_if.i_switch;
      end
      m_rise = '0;
      m_fall = '0;
      for (int n = 0; n < NSW; n++) begin
        for (int k = DEB - 1; k > 0; k--) win[n][k] = win[n][k-1];
        win[n][0] = cur[n];
        if (valid[n] < DEB) valid[n]++;
        all_diff = (valid[n] == DEB);
        for (int k = 0; k < DEB; k++)
          if (win[n][k] == m_o[n]) all_diff = 1'b0;
        if (all_diff) begin
          m_rise[n] = cur[n];
          m_fall[n] = !cur[n];
          m_o[n]    = cur[n];
          valid[n]  = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    n_cmp += 3;
    if (sw_if.o_switch !== m_o) begin
      n_bad++;
      $display("FAIL model_o_switch t=%0t got=%b want=%b", $time, sw_if.o_switch, m_o);
    end
    if (sw_if.o_rise !== m_rise) begin
      n_bad++;
      $display("FAIL model_o_rise t=%0t got=%b want=%b", $time, sw_if.o_rise, m_rise);
    end
    if (sw_if.o_fall !== m_fall) begin
      n_bad++;
      $display("FAIL model_o_fall t=%0t got=%b want=%b", $time, sw_if.o_fall, m_fall);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [NSW-1:0] act, input logic [NSW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    sw_if.i_switch = 2'b11;

    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("reset_o_switch", sw_if.o_switch, 2'b00);
      chk("reset_o_rise",   sw_if.o_rise,   2'b00);
      chk("reset_o_fall",   sw_if.o_fall,   2'b00);
    end
    rst = 1'b0;
    step(LAT - 1);
    chk("release_before", sw_if.o_switch, 2'b00);
    step(1);
    chk("release_o_switch", sw_if.o_switch, 2'b11);
    chk("release_o_rise",   sw_if.o_rise,   2'b11);
    step(1);
    chk("release_rise_one_cycle", sw_if.o_rise, 2'b00);

    sw_if.i_switch = 2'b00;
    step(LAT);
    chk("both_fall", sw_if.o_fall, 2'b11);
    step(2);

    sw_if.i_switch = 2'b01;
    step(LAT - 1);
    chk("press_before", sw_if.o_switch, 2'b00);
    step(1);
    chk("press_o_switch", sw_if.o_switch, 2'b01);
    chk("press_o_rise",   sw_if.o_rise,   2'b01);
    chk("press_o_fall",   sw_if.o_fall,   2'b00);
    step(1);
    chk("press_rise_one_cycle", sw_if.o_rise, 2'b00);
    sw_if.i_switch = 2'b00;
    step(LAT + 2);
    chk("press_released", sw_if.o_switch, 2'b00);

    sw_if.i_switch = 2'b01; step(1);
    sw_if.i_switch = 2'b00; step(1);
    sw_if.i_switch = 2'b01; step(1);
    sw_if.i_switch = 2'b00; step(1);
    sw_if.i_switch = 2'b01;
    step(LAT - 1);
    chk("bounce_before", sw_if.o_switch, 2'b00);
    step(1);
    chk("bounce_o_switch", sw_if.o_switch, 2'b01);
    chk("bounce_o_rise",   sw_if.o_rise,   2'b01);
    sw_if.i_switch = 2'b00;
    step(LAT + 2);

    sw_if.i_switch = 2'b10;
    step(DEB - 1);
    sw_if.i_switch = 2'b00;
    step(LAT + 4);
    chk("glitch_o_switch", sw_if.o_switch, 2'b00);

    sw_if.i_switch = 2'b01;
    step(LAT - 2);
    rst = 1'b1;
    step(1);
    chk("midreset_o_switch", sw_if.o_switch, 2'b00);
    chk("midreset_o_rise",   sw_if.o_rise,   2'b00);
    rst = 1'b0;
    step(LAT - 1);
    chk("midreset_before", sw_if.o_switch, 2'b00);
    step(1);
    chk("midreset_o_switch_after", sw_if.o_switch, 2'b01);
    chk("midreset_o_rise_after",   sw_if.o_rise,   2'b01);
    step(2);

    sw_if.i_switch = 2'b10;
    step(LAT);
    chk("swap_o_switch", sw_if.o_switch, 2'b10);
    chk("swap_o_rise",   sw_if.o_rise,   2'b10);
    chk("swap_o_fall",   sw_if.o_fall,   2'b01);
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
